// File: rtl/vga_compositor_pkg.sv
// Shared types, widths and default VGA timing for the compositor slice.
package vga_compositor_pkg;

    localparam int COLOR_RGB_DEPTH = 12;
    localparam int H_DISP_LEN      = 10;
    localparam int V_DISP_LEN      = 10;
    localparam int CNT_W           = 10;

    localparam int H_DISP_DEF = 640;
    localparam int H_FP_DEF   = 16;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF   = 48;

    localparam int V_DISP_DEF = 480;
    localparam int V_FP_DEF   = 10;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF   = 33;

    localparam int N_LAYERS_DEF  = 4;
    localparam int LAYER_LAT_DEF = 1;

    typedef logic [COLOR_RGB_DEPTH-1:0] rgb_t;
    typedef logic [CNT_W-1:0]           cnt_t;

    // True when v lies in the half-open window [lo, hi).
    function automatic logic inWindow(cnt_t v, cnt_t lo, cnt_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_compositor_if.sv
// Request/response bus between the compositor and its sprite/background layers.
interface vga_compositor_if
    import vga_compositor_pkg::*;
#(
    parameter int N_LAYERS = N_LAYERS_DEF
);
    logic [H_DISP_LEN-1:0]               req_x_addr;
    logic [V_DISP_LEN-1:0]               req_y_addr;
    logic                                req_v_sync;
    logic [N_LAYERS*COLOR_RGB_DEPTH-1:0] layer_rgb;
    logic [N_LAYERS-1:0]                 layer_alpha;

    modport master (
        output req_x_addr,
        output req_y_addr,
        output req_v_sync,
        input  layer_rgb,
        input  layer_alpha
    );

    modport slave (
        input  req_x_addr,
        input  req_y_addr,
        input  req_v_sync,
        output layer_rgb,
        output layer_alpha
    );
endinterface

// File: rtl/vga_compositor_timing.sv
// Free-running horizontal/vertical scan counters and raw (unaligned) sync/active flags.
module vga_timing
    import vga_compositor_pkg::*;
#(
    parameter int H_DISP = H_DISP_DEF,
    parameter int H_FP   = H_FP_DEF,
    parameter int H_SYNC = H_SYNC_DEF,
    parameter int H_BP   = H_BP_DEF,
    parameter int V_DISP = V_DISP_DEF,
    parameter int V_FP   = V_FP_DEF,
    parameter int V_SYNC = V_SYNC_DEF,
    parameter int V_BP   = V_BP_DEF
) (
    input  logic clk_vga,
    input  logic rst,
    output cnt_t hcnt_o,
    output cnt_t vcnt_o,
    output logic active_o,
    output logic hs_raw_o,
    output logic vs_raw_o
);

    localparam cnt_t H_LAST     = cnt_t'(H_DISP + H_FP + H_SYNC + H_BP - 1);
    localparam cnt_t V_LAST     = cnt_t'(V_DISP + V_FP + V_SYNC + V_BP - 1);
    localparam cnt_t H_DISP_C   = cnt_t'(H_DISP);
    localparam cnt_t V_DISP_C   = cnt_t'(V_DISP);
    localparam cnt_t HS_START   = cnt_t'(H_DISP + H_FP);
    localparam cnt_t HS_END     = cnt_t'(H_DISP + H_FP + H_SYNC);
    localparam cnt_t VS_START   = cnt_t'(V_DISP + V_FP);
    localparam cnt_t VS_END     = cnt_t'(V_DISP + V_FP + V_SYNC);

    cnt_t hCnt_q, hCnt_d;
    cnt_t vCnt_q, vCnt_d;

    // Advance the scan position; the line counter steps only when the column wraps.
    always_comb begin
        hCnt_d = hCnt_q + cnt_t'(1);
        vCnt_d = vCnt_q;
        if (hCnt_q == H_LAST) begin
            hCnt_d = '0;
            if (vCnt_q == V_LAST) begin
                vCnt_d = '0;
            end else begin
                vCnt_d = vCnt_q + cnt_t'(1);
            end
        end
    end

    // Scan position registers, returned to the top-left corner on reset.
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            hCnt_q <= '0;
            vCnt_q <= '0;
        end else begin
            hCnt_q <= hCnt_d;
            vCnt_q <= vCnt_d;
        end
    end

    assign hcnt_o   = hCnt_q;
    assign vcnt_o   = vCnt_q;
    assign active_o = (hCnt_q < H_DISP_C) && (vCnt_q < V_DISP_C);
    assign hs_raw_o = !inWindow(hCnt_q, HS_START, HS_END);
    assign vs_raw_o = !inWindow(vCnt_q, VS_START, VS_END);

endmodule

// File: rtl/vga_compositor.sv
// Pixel-request initiator and priority layer mixer producing pipeline-aligned VGA output.
module vga_compositor
    import vga_compositor_pkg::*;
#(
    parameter int   H_DISP    = H_DISP_DEF,
    parameter int   H_FP      = H_FP_DEF,
    parameter int   H_SYNC    = H_SYNC_DEF,
    parameter int   H_BP      = H_BP_DEF,
    parameter int   V_DISP    = V_DISP_DEF,
    parameter int   V_FP      = V_FP_DEF,
    parameter int   V_SYNC    = V_SYNC_DEF,
    parameter int   V_BP      = V_BP_DEF,
    parameter int   N_LAYERS  = N_LAYERS_DEF,
    parameter int   LAYER_LAT = LAYER_LAT_DEF,
    parameter rgb_t BG_RGB    = 12'h000
) (
    input  logic                    clk_vga,
    input  logic                    rst,
    input  logic                    en_i,
    vga_compositor_if.master        layer_if,
    output logic                    frame_start_o,
    output rgb_t                    vga_rgb_o,
    output logic                    vga_hs_o,
    output logic                    vga_vs_o,
    output logic                    vga_de_o
);

    cnt_t hCnt;
    cnt_t vCnt;
    logic active;
    logic hsRaw;
    logic vsRaw;

    vga_timing #(
        .H_DISP (H_DISP),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_DISP (V_DISP),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP)
    ) u_timing (
        .clk_vga  (clk_vga),
        .rst      (rst),
        .hcnt_o   (hCnt),
        .vcnt_o   (vCnt),
        .active_o (active),
        .hs_raw_o (hsRaw),
        .vs_raw_o (vsRaw)
    );

    // Outside the visible area the address is forced to all-ones so no layer can hit.
    assign layer_if.req_x_addr = active ? hCnt : '1;
    assign layer_if.req_y_addr = active ? vCnt : '1;
    assign layer_if.req_v_sync = vsRaw;

    logic [LAYER_LAT-1:0] activePipe_q;
    logic [LAYER_LAT-1:0] hsPipe_q;
    logic [LAYER_LAT-1:0] vsPipe_q;

    // Delay timing flags by the layer read latency so they line up with layer data.
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            activePipe_q <= '0;
            hsPipe_q     <= '1;
            vsPipe_q     <= '1;
        end else begin
            activePipe_q[0] <= active;
            hsPipe_q[0]     <= hsRaw;
            vsPipe_q[0]     <= vsRaw;
            for (int i = 1; i < LAYER_LAT; i++) begin
                activePipe_q[i] <= activePipe_q[i-1];
                hsPipe_q[i]     <= hsPipe_q[i-1];
                vsPipe_q[i]     <= vsPipe_q[i-1];
            end
        end
    end

    logic activeAligned;
    logic hsAligned;
    logic vsAligned;
    rgb_t mixRgb;

    assign activeAligned = activePipe_q[LAYER_LAT-1];
    assign hsAligned     = hsPipe_q[LAYER_LAT-1];
    assign vsAligned     = vsPipe_q[LAYER_LAT-1];

    // Priority pick: walking from the lowest priority upward lets layer 0 overwrite last.
    always_comb begin
        mixRgb = BG_RGB;
        for (int k = N_LAYERS - 1; k >= 0; k--) begin
            if (layer_if.layer_alpha[k]) begin
                mixRgb = layer_if.layer_rgb[k*COLOR_RGB_DEPTH +: COLOR_RGB_DEPTH];
            end
        end
    end

    rgb_t rgb_q, rgb_d;
    logic hs_q, hs_d;
    logic vs_q, vs_d;
    logic de_q, de_d;
    logic frameStart_q, frameStart_d;

    // Next values for the output stage; enable only gates colour, never timing.
    always_comb begin
        rgb_d        = '0;
        hs_d         = hsAligned;
        vs_d         = vsAligned;
        de_d         = activeAligned;
        frameStart_d = (hCnt == '0) && (vCnt == '0);
        if (activeAligned && en_i) begin
            rgb_d = mixRgb;
        end
    end

    // Output register stage; sync outputs idle high while in reset.
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            rgb_q        <= '0;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            de_q         <= 1'b0;
            frameStart_q <= 1'b0;
        end else begin
            rgb_q        <= rgb_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            de_q         <= de_d;
            frameStart_q <= frameStart_d;
        end
    end

    assign vga_rgb_o     = rgb_q;
    assign vga_hs_o      = hs_q;
    assign vga_vs_o      = vs_q;
    assign vga_de_o      = de_q;
    assign frame_start_o = frameStart_q;

endmodule

// File: tb/tb_vga_compositor.sv
// Directed self-checking bench for vga_compositor; vertical timing is shortened so a
// whole frame fits in a short run while horizontal timing keeps its real values.
module tb_vga_compositor;
    import vga_compositor_pkg::*;

    localparam int TB_V_DISP = 20;
    localparam int TB_V_FP   = 2;
    localparam int TB_V_SYNC = 2;
    localparam int TB_V_BP   = 3;
    localparam int FRAME_CLKS = 800 * (TB_V_DISP + TB_V_FP + TB_V_SYNC + TB_V_BP);
    localparam rgb_t TB_BG   = 12'h5A5;

    logic clk_vga = 1'b0;
    logic rst     = 1'b1;
    logic en_i    = 1'b1;
    logic frame_start_o;
    rgb_t vga_rgb_o;
    logic vga_hs_o;
    logic vga_vs_o;
    logic vga_de_o;

    int checks = 0;
    int errors = 0;

    logic        fillAll   = 1'b0;
    logic [3:0]  fillAlpha = 4'b0000;
    logic [47:0] fillRgb   = '0;
    cnt_t        tgtX      = 10'd1023;
    cnt_t        tgtY      = 10'd1023;
    logic [3:0]  tgtAlpha  = 4'b0000;
    logic [47:0] tgtRgb    = '0;

    vga_compositor_if #(.N_LAYERS(4)) layerBus ();

    vga_compositor #(
        .V_DISP (TB_V_DISP),
        .V_FP   (TB_V_FP),
        .V_SYNC (TB_V_SYNC),
        .V_BP   (TB_V_BP),
        .BG_RGB (TB_BG)
    ) dut (
        .clk_vga       (clk_vga),
        .rst           (rst),
        .en_i          (en_i),
        .layer_if      (layerBus.master),
        .frame_start_o (frame_start_o),
        .vga_rgb_o     (vga_rgb_o),
        .vga_hs_o      (vga_hs_o),
        .vga_vs_o      (vga_vs_o),
        .vga_de_o      (vga_de_o)
    );

    always #5 clk_vga = ~clk_vga;

    // Layer memory stand-in: one-clock read latency, either a flat fill or one target pixel.
    always @(posedge clk_vga) begin
        if (fillAll) begin
            layerBus.layer_alpha <= fillAlpha;
            layerBus.layer_rgb   <= fillRgb;
        end else if (layerBus.req_x_addr == tgtX && layerBus.req_y_addr == tgtY) begin
            layerBus.layer_alpha <= tgtAlpha;
            layerBus.layer_rgb   <= tgtRgb;
        end else begin
            layerBus.layer_alpha <= 4'b0000;
            layerBus.layer_rgb   <= '0;
        end
    end

    task automatic waitReq(input cnt_t x, input cnt_t y, input bit anyY, input int limit,
                           output bit found);
        found = 1'b0;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk_vga);
            if (layerBus.req_x_addr == x && (anyY || layerBus.req_y_addr == y)) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_vga);
        checks++; if (vga_rgb_o !== 12'h000) begin errors++; $display("[TB] FAIL reset_rgb got %h want 000", vga_rgb_o); end
        checks++; if (vga_hs_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_hs got %b want 1", vga_hs_o); end
        checks++; if (vga_vs_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_vs got %b want 1", vga_vs_o); end
        checks++; if (vga_de_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_de got %b want 0", vga_de_o); end
        checks++; if (frame_start_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_fs got %b want 0", frame_start_o); end
        checks++; if (layerBus.req_x_addr !== 10'd0 || layerBus.req_y_addr !== 10'd0) begin
            errors++; $display("[TB] FAIL reset_req got (%0d,%0d) want (0,0)", layerBus.req_x_addr, layerBus.req_y_addr);
        end
        checks++; if (layerBus.req_v_sync !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_vsync got %b want 1", layerBus.req_v_sync); end
    endtask

    task automatic test_line_timing();
        int hsLow = 0, deHigh = 0, firstHs = -1, firstDe = -1;
        rst = 1'b0;
        for (int k = 1; k <= 800; k++) begin
            @(negedge clk_vga);
            if (vga_hs_o === 1'b0) begin hsLow++; if (firstHs < 0) firstHs = k; end
            if (vga_de_o === 1'b1) begin deHigh++; if (firstDe < 0) firstDe = k; end
        end
        checks++; if (hsLow !== 96) begin errors++; $display("[TB] FAIL hs_low_len got %0d want 96", hsLow); end
        checks++; if (firstHs !== 658) begin errors++; $display("[TB] FAIL hs_fall_clk got %0d want 658", firstHs); end
        checks++; if (deHigh !== 640) begin errors++; $display("[TB] FAIL de_len got %0d want 640", deHigh); end
        checks++; if (firstDe !== 2) begin errors++; $display("[TB] FAIL de_rise_clk got %0d want 2", firstDe); end
    endtask

    task automatic test_frame_sync();
        int vsLow = 0, reqVsLow = 0, fsCount = 0;
        for (int k = 0; k < FRAME_CLKS; k++) begin
            @(negedge clk_vga);
            if (vga_vs_o === 1'b0) vsLow++;
            if (layerBus.req_v_sync === 1'b0) reqVsLow++;
            if (frame_start_o === 1'b1) fsCount++;
        end
        checks++; if (vsLow !== 1600) begin errors++; $display("[TB] FAIL vs_low_len got %0d want 1600", vsLow); end
        checks++; if (reqVsLow !== 1600) begin errors++; $display("[TB] FAIL req_vsync_len got %0d want 1600", reqVsLow); end
        checks++; if (fsCount !== 1) begin errors++; $display("[TB] FAIL frame_start_count got %0d want 1", fsCount); end
    endtask

    task automatic test_priority();
        cnt_t        vx[5]     = '{10'd10, 10'd40, 10'd70, 10'd100, 10'd130};
        logic [3:0]  vAlpha[5] = '{4'b0110, 4'b1000, 4'b0000, 4'b1111, 4'b0100};
        logic [47:0] vRgb[5]   = '{{12'hFFF, 12'h0F0, 12'hF00, 12'h00F},
                                   {12'hABC, 12'h111, 12'h222, 12'h333},
                                   {12'h444, 12'h555, 12'h666, 12'h777},
                                   {12'h888, 12'h999, 12'hAAA, 12'h00F},
                                   {12'hCCC, 12'h0F0, 12'hDDD, 12'hEEE}};
        rgb_t        vExp[5]   = '{12'hF00, 12'hABC, TB_BG, 12'h00F, 12'h0F0};
        bit found;
        fillAll = 1'b0;
        for (int v = 0; v < 5; v++) begin
            tgtX = vx[v]; tgtY = 10'd5; tgtAlpha = vAlpha[v]; tgtRgb = vRgb[v];
            waitReq(vx[v], 10'd5, 1'b0, 30000, found);
            checks++;
            if (!found) begin
                errors++; $display("[TB] FAIL prio_wait_%0d timeout got none want (%0d,5)", v, vx[v]);
            end else begin
                repeat (2) @(negedge clk_vga);
                if (vga_rgb_o !== vExp[v] || vga_de_o !== 1'b1) begin
                    errors++; $display("[TB] FAIL prio_%0d got rgb=%h de=%b want rgb=%h de=1", v, vga_rgb_o, vga_de_o, vExp[v]);
                end
                @(negedge clk_vga);
                checks++;
                if (vga_rgb_o !== TB_BG) begin
                    errors++; $display("[TB] FAIL prio_next_%0d got %h want %h", v, vga_rgb_o, TB_BG);
                end
            end
        end
    endtask

    task automatic test_blanking();
        bit found;
        fillAll = 1'b1; fillAlpha = 4'b1111; fillRgb = {12'h321, 12'h654, 12'h987, 12'h123};
        waitReq(10'h3FF, 10'h3FF, 1'b0, 2000, found);
        checks++;
        if (!found) begin
            errors++; $display("[TB] FAIL blank_req timeout got (%h,%h) want (3ff,3ff)", layerBus.req_x_addr, layerBus.req_y_addr);
        end else begin
            repeat (2) @(negedge clk_vga);
            if (vga_rgb_o !== 12'h000 || vga_de_o !== 1'b0) begin
                errors++; $display("[TB] FAIL blank_rgb got rgb=%h de=%b want rgb=000 de=0", vga_rgb_o, vga_de_o);
            end
        end
        waitReq(10'd0, 10'd0, 1'b1, 2000, found);
        checks++;
        if (!found) begin
            errors++; $display("[TB] FAIL blank_resume timeout got none want req_x=0");
        end else begin
            repeat (2) @(negedge clk_vga);
            if (vga_rgb_o !== 12'h123 || vga_de_o !== 1'b1) begin
                errors++; $display("[TB] FAIL active_fill got rgb=%h de=%b want rgb=123 de=1", vga_rgb_o, vga_de_o);
            end
        end
    endtask

    task automatic test_enable();
        int hsLow = 0, deHigh = 0, rgbOn = 0;
        bit found;
        fillAll = 1'b1; fillAlpha = 4'b0001; fillRgb = {12'h111, 12'h222, 12'h333, 12'h7E7};
        en_i = 1'b0;
        for (int k = 0; k < 800; k++) begin
            @(negedge clk_vga);
            if (vga_hs_o === 1'b0) hsLow++;
            if (vga_de_o === 1'b1) deHigh++;
            if (vga_rgb_o !== 12'h000) rgbOn++;
        end
        checks++; if (hsLow !== 96) begin errors++; $display("[TB] FAIL en0_hs_len got %0d want 96", hsLow); end
        checks++; if (deHigh !== 640) begin errors++; $display("[TB] FAIL en0_de_len got %0d want 640", deHigh); end
        checks++; if (rgbOn !== 0) begin errors++; $display("[TB] FAIL en0_rgb_nonzero got %0d want 0", rgbOn); end
        waitReq(10'd100, 10'd0, 1'b1, 2000, found);
        checks++;
        if (!found) begin
            errors++; $display("[TB] FAIL en_wait timeout got none want req_x=100");
        end else begin
            repeat (2) @(negedge clk_vga);
            if (vga_rgb_o !== 12'h000 || vga_de_o !== 1'b1) begin
                errors++; $display("[TB] FAIL en0_pixel got rgb=%h de=%b want rgb=000 de=1", vga_rgb_o, vga_de_o);
            end
            en_i = 1'b1;
            @(negedge clk_vga);
            checks++;
            if (vga_rgb_o !== 12'h7E7) begin
                errors++; $display("[TB] FAIL en1_pixel got %h want 7e7", vga_rgb_o);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        waitReq(10'd300, 10'd10, 1'b0, 25000, found);
        checks++;
        if (!found) begin
            errors++; $display("[TB] FAIL rst_mid_wait timeout got none want (300,10)");
        end else begin
            rst = 1'b1;
            #1;
            if (vga_rgb_o !== 12'h000 || vga_de_o !== 1'b0 || vga_hs_o !== 1'b1 ||
                vga_vs_o !== 1'b1 || frame_start_o !== 1'b0) begin
                errors++; $display("[TB] FAIL rst_mid_out got rgb=%h de=%b hs=%b vs=%b fs=%b want 000 0 1 1 0",
                                   vga_rgb_o, vga_de_o, vga_hs_o, vga_vs_o, frame_start_o);
            end
            checks++;
            if (layerBus.req_x_addr !== 10'd0 || layerBus.req_y_addr !== 10'd0) begin
                errors++; $display("[TB] FAIL rst_mid_req got (%0d,%0d) want (0,0)", layerBus.req_x_addr, layerBus.req_y_addr);
            end
            @(negedge clk_vga);
            rst = 1'b0;
            #1;
            checks++;
            if (layerBus.req_x_addr !== 10'd0 || layerBus.req_y_addr !== 10'd0) begin
                errors++; $display("[TB] FAIL rst_rel_req got (%0d,%0d) want (0,0)", layerBus.req_x_addr, layerBus.req_y_addr);
            end
            @(negedge clk_vga);
            checks++;
            if (layerBus.req_x_addr !== 10'd1 || layerBus.req_y_addr !== 10'd0) begin
                errors++; $display("[TB] FAIL rst_rel_step got (%0d,%0d) want (1,0)", layerBus.req_x_addr, layerBus.req_y_addr);
            end
            @(negedge clk_vga);
            checks++;
            if (vga_rgb_o !== 12'h7E7 || vga_de_o !== 1'b1) begin
                errors++; $display("[TB] FAIL rst_rel_pixel got rgb=%h de=%b want rgb=7e7 de=1", vga_rgb_o, vga_de_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_frame_sync();
        test_priority();
        test_blanking();
        test_enable();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
